// File: rtl/audio_i2s_tx.sv
// Stereo I2S transmitter: one-deep holding register per channel, BCLK/LRCK
// mastered from clk, MSB one bit after each LRCK edge, saturating underflow count.
module audio_i2s_tx #(
  parameter int BCLK_HALF = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] L_DATA,
  input  logic        L_VALID,
  output logic        L_READY,
  input  logic [15:0] R_DATA,
  input  logic        R_VALID,
  output logic        R_READY,
  input  logic        underflow_clr,
  output logic [15:0] underflow_cnt,
  output logic        AUD_BCLK,
  output logic        AUD_DACLRCK,
  output logic        AUD_DACDAT
);

  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic             bclk_reg, bclk_next;
  logic [5:0]       bit_cnt_reg, bit_cnt_next;
  logic             lrck_reg, lrck_next;
  logic             dacdat_reg, dacdat_next;
  logic [15:0]      shift_reg, shift_next;
  logic [15:0]      ucnt_reg, ucnt_next;

  logic        tick;
  logic        fall_evt;
  logic [5:0]  bit_cnt_inc;
  logic        load_evt;
  logic        load_ch;
  logic        underflow_evt;

  logic [15:0] in_data [2];
  logic [1:0]  in_valid;
  logic [1:0]  ready_vec;
  logic [1:0]  full_vec;
  logic [15:0] hold_vec [2];

  assign in_data[0] = L_DATA;
  assign in_data[1] = R_DATA;
  assign in_valid   = {R_VALID, L_VALID};
  assign L_READY    = ready_vec[0];
  assign R_READY    = ready_vec[1];

  assign tick        = enable && (div_cnt_reg == DIV_LAST);
  assign fall_evt    = tick && bclk_reg;
  assign bit_cnt_inc = bit_cnt_reg + 6'd1;
  assign load_evt    = fall_evt && (bit_cnt_inc[4:0] == 5'd0);
  assign load_ch     = bit_cnt_inc[5];
  // Loads look at the pre-edge full flag, so a same-edge accept lands in the next slot.
  assign underflow_evt = load_evt && !full_vec[load_ch];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic        full_reg, full_next;
      logic [15:0] hold_reg, hold_next;
      logic        load_sel;

      assign ready_vec[gi] = !full_reg && enable;
      assign load_sel      = load_evt && (load_ch == 1'(gi));
      assign full_vec[gi]  = full_reg;
      assign hold_vec[gi]  = hold_reg;

      always_comb begin
        full_next = full_reg;
        hold_next = hold_reg;
        if (in_valid[gi] && ready_vec[gi]) begin
          full_next = 1'b1;
          hold_next = in_data[gi];
        end else if (load_sel) begin
          full_next = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          full_reg <= 1'b0;
          hold_reg <= '0;
        end else begin
          full_reg <= full_next;
          hold_reg <= hold_next;
        end
      end
    end
  endgenerate

  always_comb begin
    div_cnt_next = div_cnt_reg;
    bclk_next    = bclk_reg;
    bit_cnt_next = bit_cnt_reg;
    lrck_next    = lrck_reg;
    dacdat_next  = dacdat_reg;
    shift_next   = shift_reg;
    if (enable) begin
      div_cnt_next = tick ? '0 : div_cnt_reg + 1'b1;
    end
    if (tick) begin
      bclk_next = ~bclk_reg;
    end
    if (fall_evt) begin
      bit_cnt_next = bit_cnt_inc;
      lrck_next    = bit_cnt_inc[5];
      if (load_evt) begin
        shift_next  = full_vec[load_ch] ? hold_vec[load_ch] : 16'h0000;
        dacdat_next = 1'b0;
      end else if (bit_cnt_inc[4:0] <= 5'd16) begin
        dacdat_next = shift_reg[15];
        shift_next  = {shift_reg[14:0], 1'b0};
      end else begin
        dacdat_next = 1'b0;
      end
    end
  end

  always_comb begin
    ucnt_next = ucnt_reg;
    if (underflow_clr) begin
      ucnt_next = 16'h0000;
    end else if (underflow_evt && (ucnt_reg != 16'hFFFF)) begin
      ucnt_next = ucnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_reg <= '0;
      bclk_reg    <= 1'b0;
      bit_cnt_reg <= 6'd63;
      lrck_reg    <= 1'b1;
      dacdat_reg  <= 1'b0;
      shift_reg   <= '0;
      ucnt_reg    <= '0;
    end else begin
      div_cnt_reg <= div_cnt_next;
      bclk_reg    <= bclk_next;
      bit_cnt_reg <= bit_cnt_next;
      lrck_reg    <= lrck_next;
      dacdat_reg  <= dacdat_next;
      shift_reg   <= shift_next;
      ucnt_reg    <= ucnt_next;
    end
  end

  assign AUD_BCLK      = bclk_reg;
  assign AUD_DACLRCK   = lrck_reg;
  assign AUD_DACDAT    = dacdat_reg;
  assign underflow_cnt = ucnt_reg;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: a frame-level model predicts each slot's word at its
// load edge; a monitor rebuilds words from the serial pins and compares.
module tb_audio_i2s_tx;
  localparam int BH   = 8;
  localparam int SLOT = 32 * 2 * BH;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] L_DATA = '0;
  logic        L_VALID = 1'b0;
  logic        L_READY;
  logic [15:0] R_DATA = '0;
  logic        R_VALID = 1'b0;
  logic        R_READY;
  logic        underflow_clr = 1'b0;
  logic [15:0] underflow_cnt;
  logic        AUD_BCLK, AUD_DACLRCK, AUD_DACDAT;

  audio_i2s_tx #(.BCLK_HALF(BH)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .L_DATA(L_DATA), .L_VALID(L_VALID), .L_READY(L_READY),
    .R_DATA(R_DATA), .R_VALID(R_VALID), .R_READY(R_READY),
    .underflow_clr(underflow_clr), .underflow_cnt(underflow_cnt),
    .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK), .AUD_DACDAT(AUD_DACDAT)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: enabled-edge count since reset decides slot timing.
  typedef struct { int ch; logic [15:0] w; } exp_t;
  exp_t        exp_q[$];
  int          n_en;
  bit          m_full[2];
  logic [15:0] m_hold[2];
  int          m_cnt;
  int          acc_cnt[2];
  bit          fp[2];
  bit          vin[2];
  logic [15:0] din[2];
  bit          m_inc;
  int          m_ch;
  exp_t        e_new;

  initial begin
    n_en = 0; m_cnt = 0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        n_en = 0; m_cnt = 0; exp_q.delete();
        for (int c = 0; c < 2; c++) begin m_full[c] = 0; m_hold[c] = '0; acc_cnt[c] = 0; end
      end else begin
        m_inc = 0;
        if (enable) begin
          n_en++;
          fp = m_full;
          if (n_en >= 2 * BH && (n_en - 2 * BH) % SLOT == 0) begin
            m_ch = ((n_en - 2 * BH) / SLOT) % 2;
            e_new.ch = m_ch;
            if (fp[m_ch]) e_new.w = m_hold[m_ch];
            else begin e_new.w = 16'h0000; m_inc = 1; end
            m_full[m_ch] = 0;
            exp_q.push_back(e_new);
          end
          vin[0] = L_VALID; din[0] = L_DATA;
          vin[1] = R_VALID; din[1] = R_DATA;
          for (int c = 0; c < 2; c++)
            if (vin[c] && !fp[c]) begin
              m_hold[c] = din[c]; m_full[c] = 1; acc_cnt[c]++;
            end
        end
        if (underflow_clr) m_cnt = 0;
        else if (m_inc && m_cnt < 65535) m_cnt++;
      end
    end
  end

  // Checker / slot monitor, 3 ns after each rising clk edge.
  int          idx = -1;
  bit          prev_bclk = 0;
  bit          prev_lrck = 1;
  logic [15:0] word;
  bit          tail_bad;
  int          cur_ch;
  int          last_n = -1;
  bit          last_dac;
  exp_t        e_pop;

  initial begin
    forever begin
      @(posedge clk);
      #3;
      check("bclk", int'(AUD_BCLK), (n_en / BH) % 2);
      check("lrck", int'(AUD_DACLRCK), ((63 + n_en / (2 * BH)) % 64) / 32);
      check("underflow_cnt", int'(underflow_cnt), m_cnt);
      check("l_ready", int'(L_READY), int'(!m_full[0] && enable));
      check("r_ready", int'(R_READY), int'(!m_full[1] && enable));
      if (!reset_n) begin
        check("dacdat_rst", int'(AUD_DACDAT), 0);
        idx = -1; prev_bclk = 0; prev_lrck = 1; last_n = -1;
      end else begin
        if (n_en == last_n) check("dacdat_frozen", int'(AUD_DACDAT), int'(last_dac));
        last_n = n_en; last_dac = AUD_DACDAT;
        if (AUD_BCLK && !prev_bclk) begin
          if (AUD_DACLRCK != prev_lrck) begin
            idx = 0; word = '0; tail_bad = 0; cur_ch = int'(AUD_DACLRCK);
          end
          if (idx >= 0) begin
            if (idx >= 1 && idx <= 16) word[16 - idx] = AUD_DACDAT;
            else if (AUD_DACDAT) tail_bad = 1;
            idx++;
            if (idx == 32) begin
              if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL slot_unexpected at %0t: got ch%0d word 0x%04h, expected no slot", $time, cur_ch, word);
              end else begin
                e_pop = exp_q.pop_front();
                check("slot_ch", cur_ch, e_pop.ch);
                check("slot_word", int'(word), int'(e_pop.w));
                check("slot_pad_zero", int'(tail_bad), 0);
              end
              idx = -1;
            end
          end
          prev_lrck = AUD_DACLRCK;
        end
        prev_bclk = AUD_BCLK;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic offer(input int ch, input logic [15:0] d);
    int waited = 0;
    @(negedge clk);
    while ((m_full[ch] || !enable) && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL offer_timeout ch%0d: got no ready in 3000 cycles, expected ready", ch);
    end
    if (ch == 0) begin L_VALID = 1'b1; L_DATA = d; end
    else         begin R_VALID = 1'b1; R_DATA = d; end
    @(negedge clk);
    L_VALID = 1'b0; R_VALID = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish by 5 ms, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  logic [15:0] rnd;
  int last_acc;

  initial begin
    // Basic stereo frame
    do_reset();
    offer(0, 16'h8001);
    offer(1, 16'h7FFE);
    repeat (1015) @(negedge clk);
    check("no_underflow_frame1", int'(underflow_cnt), 0);
    repeat (600) @(negedge clk);

    // Idle: underflow every slot, clear wins over increment
    do_reset();
    repeat (1024) @(negedge clk);
    check("underflow_1frame", int'(underflow_cnt), 2);
    repeat (9216) @(negedge clk);
    check("underflow_10frames", int'(underflow_cnt), 20);
    repeat (15) @(negedge clk);
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    check("clr_beats_inc", int'(underflow_cnt), 0);
    repeat (40) @(negedge clk);

    // Continuous handshake with incrementing data
    do_reset();
    L_VALID = 1'b1; L_DATA = 16'h0001; last_acc = 0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      if (acc_cnt[0] != last_acc) begin
        last_acc = acc_cnt[0];
        L_DATA = 16'(last_acc + 1);
      end
    end
    check("left_accepts_4096clk", acc_cnt[0], 5);
    L_VALID = 1'b0;
    repeat (1200) @(negedge clk);

    // Accept coinciding with left load edge
    do_reset();
    repeat (15) @(negedge clk);
    L_VALID = 1'b1; L_DATA = 16'h1234;
    @(negedge clk);
    L_VALID = 1'b0;
    check("coincident_underflow", int'(underflow_cnt), 1);
    check("coincident_accepted", acc_cnt[0], 1);
    repeat (1700) @(negedge clk);

    // Enable pause mid-slot
    do_reset();
    rnd = 16'($urandom);
    offer(0, rnd);
    offer(1, 16'($urandom));
    repeat (150) @(negedge clk);
    enable = 1'b0;
    repeat (100) @(negedge clk);
    enable = 1'b1;
    repeat (1200) @(negedge clk);

    // Reset mid-frame with both channels holding samples
    do_reset();
    offer(1, 16'hA5A5);
    repeat (30) @(negedge clk);
    offer(0, 16'h5A5A);
    repeat (250) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_bclk", int'(AUD_BCLK), 0);
    check("midrst_lrck", int'(AUD_DACLRCK), 1);
    check("midrst_dacdat", int'(AUD_DACDAT), 0);
    check("midrst_cnt", int'(underflow_cnt), 0);
    check("midrst_l_ready", int'(L_READY), 1);
    check("midrst_r_ready", int'(R_READY), 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("postrst_underflow", int'(underflow_cnt), 1);
    repeat (1100) @(negedge clk);

    // Random traffic with occasional enable drops
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      L_VALID = ($urandom_range(0, 99) < 4);
      L_DATA  = 16'($urandom);
      R_VALID = ($urandom_range(0, 99) < 4);
      R_DATA  = 16'($urandom);
      enable  = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    L_VALID = 1'b0; R_VALID = 1'b0; enable = 1'b1;
    repeat (1200) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
